fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  F stage of the 5-stage pipelined MIPS core: PC register, next-PC select and the F/D pipeline flip-flop.
//  Drives instruction memory and feeds d_instr/d_pc/d_pc4 to the pipelined control unit and D-stage datapath.
//  Takes stall enables (pc_enable, pff_enable) and the E-stage jump mode from control; the branch/jump is resolved here.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC value after reset
//  NOP_INSTR   32'h0000_0000  word loaded into F/D on reset/flush
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  reset         in   1   asynchronous, active-high reset
//  pc_enable     in   1   1 = PC may advance sequentially; 0 = stall (hold)
//  pff_enable    in   1   1 = F/D register loads; 0 = hold
//  npc_jump_mode in   3   0 DISABLED, 1 WHEN_EQUAL, 2 J, 3 REG; 4-7 treated as DISABLED
//  cmp_a         in   32  forwarded rs value of the E-stage instr (beq compare)
//  cmp_b         in   32  forwarded rt value of the E-stage instr
//  br_pc4        in   32  PC+4 of the E-stage instr
//  br_instr      in   32  E-stage instruction word (imm16 / index26 source)
//  reg_target    in   32  forwarded rs value for REG (jr/jalr)
//  imem_addr     out  32  fetch address (= f_pc), combinational read
//  imem_rdata    in   32  instruction word at imem_addr, same cycle
//  f_pc          out  32  current PC
//  d_instr       out  32  F/D instruction
//  d_pc          out  32  F/D PC
//  d_pc4         out  32  F/D PC+4
//  redirect      out  1   combinational: taken branch/jump this cycle
//  align_err     out  1   sticky: a redirect target had [1:0] != 0
// BEHAVIOUR
//  Reset (async, any time, including mid-stall): f_pc=RESET_PC, d_instr=NOP_INSTR, d_pc=0, d_pc4=0, align_err=0.
//  redirect = (mode==2)|(mode==3)|(mode==1 & cmp_a==cmp_b).
//  Target: WHEN_EQUAL -> br_pc4 + (sext(br_instr[15:0])<<2); J -> {br_pc4[31:28],br_instr[25:0],2'b00};
//    REG -> {reg_target[31:2],2'b00}. All adds mod 2^32 (wrap, no overflow flag).
//  PC next: redirect -> target (regardless of pc_enable; E-stage branch leaves E next edge and is not replayed);
//    else pc_enable -> f_pc+4 (0xFFFF_FFFC wraps to 0); else hold.
//  align_err set on any edge where redirect & target_raw[1:0]!=0; only reset clears it.
//  F/D: pff_enable=1 -> d_instr<=imem_rdata, d_pc<=f_pc, d_pc4<=f_pc+4; pff_enable=0 -> all three hold.
//  Latency: instr at f_pc visible on d_instr one edge after fetch; redirect takes effect on f_pc one edge later.
//  No internal state machine beyond PC/F/D/align_err; no handshake with imem (single-cycle ROM).
//  Without flush, the instruction in F at redirect proceeds (delay-slot semantics, matches MARS with delay slots).
// CONFIGURATION
//  FLUSH_ON_REDIRECT_EN defined: on an edge with redirect=1, F/D loads d_instr<=NOP_INSTR, d_pc<=0, d_pc4<=0,
//    overriding pff_enable=0 (wrong-path squash, no delay slot).
//  Not defined: redirect never touches F/D; delay-slot semantics as above.
// TESTING
//  1 reset mid-run, imem returns 0x3401_0001 -> f_pc=0x3000, d_instr=0 immediately (async); first edge d_instr=0x3401_0001, d_pc=0x3000.
//  2 pc_enable=pff_enable=0 for 3 cycles at f_pc=0x3008 -> f_pc, d_instr, d_pc unchanged; release -> f_pc=0x300C next edge.
//  3 mode=1, cmp_a=cmp_b=5, br_pc4=0x3010, imm16=0xFFFE -> redirect=1, f_pc=0x3008 next edge; cmp_b=6 -> f_pc+4.
//  4 mode=3, reg_target=0x0000_3402 with pc_enable=0 -> f_pc=0x3400, align_err=1 and stays 1 until reset.
//  5 mode=2, br_pc4=0x9000_0004, index26=0x0000_100 -> f_pc=0x9000_0400.
//  6 f_pc forced to 0xFFFF_FFFC, mode=0 -> f_pc=0 next edge; with FLUSH_ON_REDIRECT_EN, taken beq + pff_enable=0 -> d_instr=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC select with E-stage branch/jump resolution, and the F/D pipeline register.
// Optional macro FLUSH_ON_REDIRECT_EN squashes the F/D register on a taken redirect (no delay slot).
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_enable,
    input  logic        pff_enable,
    input  logic [2:0]  npc_jump_mode,
    input  logic [31:0] cmp_a,
    input  logic [31:0] cmp_b,
    input  logic [31:0] br_pc4,
    input  logic [31:0] br_instr,
    input  logic [31:0] reg_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] f_pc,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc4,
    output logic        redirect,
    output logic        align_err
);

    typedef enum logic [2:0] {
        JM_DISABLED   = 3'd0,
        JM_WHEN_EQUAL = 3'd1,
        JM_J          = 3'd2,
        JM_REG        = 3'd3
    } jump_mode_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_pc4_q, d_pc4_d;
    logic        align_err_q, align_err_d;

    logic [31:0] pc_plus4;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redirect_c;

    assign pc_plus4 = pc_q + 32'd4;

    // target_raw keeps reg_target's low bits so a misaligned jr/jalr target is still visible to align_err.
    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        redirect_c = 1'b0;
        target_raw = 32'd0;
        case (npc_jump_mode)
            JM_WHEN_EQUAL: begin
                redirect_c = (cmp_a == cmp_b);
                target_raw = br_pc4 + {{14{br_instr[15]}}, br_instr[15:0], 2'b00};
            end
            JM_J: begin
                redirect_c = 1'b1;
                target_raw = {br_pc4[31:28], br_instr[25:0], 2'b00};
            end
            JM_REG: begin
                redirect_c = 1'b1;
                target_raw = reg_target;
            end
            default: begin
                redirect_c = 1'b0;
                target_raw = 32'd0;
            end
        endcase
    end

    assign target = {target_raw[31:2], 2'b00};

    // A redirect wins over a PC stall: the branch leaves E on this edge and is never replayed.
    always_comb begin
        pc_d        = pc_q;
        align_err_d = align_err_q | (redirect_c & (target_raw[1:0] != 2'b00));
        if (redirect_c) begin
            pc_d = target;
        end else if (pc_enable) begin
            pc_d = pc_plus4;
        end
    end

    always_comb begin
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        d_pc4_d   = d_pc4_q;
`ifdef FLUSH_ON_REDIRECT_EN
        if (redirect_c) begin
            d_instr_d = NOP_INSTR;
            d_pc_d    = 32'd0;
            d_pc4_d   = 32'd0;
        end else if (pff_enable) begin
            d_instr_d = imem_rdata;
            d_pc_d    = pc_q;
            d_pc4_d   = pc_plus4;
        end
`else
        if (pff_enable) begin
            d_instr_d = imem_rdata;
            d_pc_d    = pc_q;
            d_pc4_d   = pc_plus4;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            d_instr_q   <= NOP_INSTR;
            d_pc_q      <= 32'd0;
            d_pc4_q     <= 32'd0;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            d_instr_q   <= d_instr_d;
            d_pc_q      <= d_pc_d;
            d_pc4_q     <= d_pc4_d;
            align_err_q <= align_err_d;
        end
    end

    assign imem_addr = pc_q;
    assign f_pc      = pc_q;
    assign d_instr   = d_instr_q;
    assign d_pc      = d_pc_q;
    assign d_pc4     = d_pc4_q;
    assign redirect  = redirect_c;
    assign align_err = align_err_q;

endmodule
